inst_seq_buff: RTL and testbench
================================

// Module: inst_seq_buff
// PURPOSE
//   Parametrised instruction buffer with a built-in fetch sequencer, for the engine front end.
//   The host loads the program through a write port while the block is idle.
//   A start command then streams instructions from a start address to the decoder over a valid/ready handshake.
//   Streaming stops automatically at a halt word, or when stop is asserted.
// PARAMETERS
//   INST_WIDTH   25        instruction width in bits (>= 3)
//   INST_COUNT   64        buffer depth; power of two >= 2
//   HALT_OPCODE  2'b11     top-2-bit opcode marking a halt word; halt word = {HALT_OPCODE, zeros}
//   AW           $clog2(INST_COUNT)  address width (derived, do not override)
// PORTS
//   clk          in   1           rising-edge clock
//   reset        in   1           asynchronous, active-low reset
//   wr_en        in   1           program-load write strobe
//   wr_addr      in   AW          write address
//   wr_data      in   INST_WIDTH  write data
//   wr_err       out  1           1-cycle pulse: write attempted while busy (write dropped)
//   start        in   1           begin streaming at start_addr
//   start_addr   in   AW          first fetch address
//   stop         in   1           abort streaming
//   inst_out     out  INST_WIDTH  instruction presented to the decoder
//   inst_pc      out  AW          buffer address of inst_out
//   inst_valid   out  1           inst_out valid
//   inst_ready   in   1           decoder accepts inst_out
//   busy         out  1           1 while the FSM is in RUN
//   done         out  1           1-cycle pulse: halt word reached
// BEHAVIOUR
//   Reset (reset=0, async)
//     - every entry = halt word; FSM = IDLE
//     - inst_out = halt word; inst_pc = 0
//     - inst_valid, busy, done and wr_err all 0
//   FSM states: IDLE, RUN, HALT. HALT behaves as IDLE, but records that the last run ended on a halt word.
//   Writes
//     - In IDLE/HALT, wr_en writes mem[wr_addr] at the clock edge.
//     - In RUN, wr_en is dropped and wr_err pulses high on the next cycle.
//   Start (IDLE/HALT, start=1 at edge T)
//     - pc <= start_addr; inst_out <= mem[start_addr].
//     - If wr_en=1 in the same cycle and wr_addr==start_addr, wr_data is forwarded into inst_out. The write also commits.
//     - If the loaded word's top 2 bits equal HALT_OPCODE: inst_valid stays 0, state -> HALT, and done=1 in cycle T+1.
//     - Otherwise: state -> RUN, and inst_valid=1 from T+1 (latency 1).
//     - start while in RUN is ignored.
//   Streaming (RUN)
//     - inst_out, inst_pc and inst_valid are held stable until inst_valid & inst_ready.
//     - On a handshake: pc <= pc+1 (wrap INST_COUNT-1 -> 0) and inst_out <= mem[pc+1], with no bubble.
//     - Back-to-back handshakes give 1 instruction per cycle.
//     - If the next word is a halt word: inst_valid -> 0, state -> HALT, and done pulses.
//     - The halt word is never presented with valid=1.
//     - A buffer with no halt word wraps indefinitely.
//   Stop
//     - stop=1 in RUN: state -> IDLE and inst_valid -> 0 next cycle; no done pulse.
//     - stop together with a handshake: the handshake completes (the instruction is consumed), then stop wins. No next fetch is presented.
//     - stop together with start in IDLE: stop wins, state stays IDLE.
//     - stop in IDLE/HALT has no effect.
//   Reset mid-run: asynchronously returns to the reset values above; the buffer contents are lost.
//   inst_pc always equals the address inst_out was read from; the pc is AW bits, modulo INST_COUNT.
// TESTING
//   1. Reset, then start@0 with no load -> done pulses at T+1, inst_valid never 1, busy stays 0.
//   2. Load 0..3 = 0x0000001..0x0000004 and 4 = halt word; start@0, inst_ready=1 -> valid 1s at pc 0..3 on consecutive cycles, then done and state HALT.
//   3. Same program, inst_ready toggled 1/0 -> each word is held until accepted; no loss or duplication; 4 words total.
//   4. Load 62 = 0xA, 63 = 0xB, 0 = 0xC, 1 = halt; start@62 -> words sequence 0xA, 0xB, 0xC with pc 62, 63, 0 (wrap), then done.
//   5. During RUN: wr_en@5 -> wr_err pulses and mem[5] is unchanged. Then stop with a handshake at pc 2 -> pc 2 consumed, valid 0, IDLE, no done.
//   6. In IDLE: wr_en@7 = 0x15 together with start@7 -> inst_out = 0x15 at T+1 (forwarded). Then assert reset low mid-run -> all outputs at reset values immediately.

Source files
------------

// File: rtl/inst_seq_buff_if.sv
// ============================================================================
// Module      : inst_seq_buff_if
// Description : Host-load, control and decoder-stream signals of the
//               instruction sequence buffer, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_seq_buff_if #(
    parameter int INST_WIDTH = 25,
    parameter int AW         = 6
);
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [INST_WIDTH-1:0] wr_data;
    logic                  wr_err;
    logic                  start;
    logic [AW-1:0]         start_addr;
    logic                  stop;
    logic [INST_WIDTH-1:0] inst_out;
    logic [AW-1:0]         inst_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic                  busy;
    logic                  done;

    // Host / decoder side
    modport master (
        output wr_en, wr_addr, wr_data, start, start_addr, stop, inst_ready,
        input  wr_err, inst_out, inst_pc, inst_valid, busy, done
    );

    // Buffer side
    modport slave (
        input  wr_en, wr_addr, wr_data, start, start_addr, stop, inst_ready,
        output wr_err, inst_out, inst_pc, inst_valid, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/inst_seq_buff.sv
// ============================================================================
// Module      : inst_seq_buff
// Description : Instruction buffer with fetch sequencer. Loaded by the host
//               while idle, then streams words from a start address to the
//               decoder over valid/ready until a halt word or a stop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_seq_buff #(
    parameter int         INST_WIDTH  = 25,
    parameter int         INST_COUNT  = 64,
    parameter logic [1:0] HALT_OPCODE = 2'b11,
    parameter int         AW          = $clog2(INST_COUNT)
) (
    input  wire logic          clk_i,
    input  wire logic          reset_ni,
    inst_seq_buff_if.slave     bus_s
);

    localparam logic [INST_WIDTH-1:0] c_HALT_WORD =
        {HALT_OPCODE, {(INST_WIDTH-2){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                state_q;
    logic [INST_WIDTH-1:0] mem_q [INST_COUNT];
    logic [AW-1:0]         pc_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  valid_q;
    logic                  done_q;
    logic                  wr_err_q;

    logic                  w_running;
    logic                  w_wr_ok;
    logic                  w_handshake;
    logic [AW-1:0]         w_pc_d;
    logic [INST_WIDTH-1:0] w_start_word;
    logic [INST_WIDTH-1:0] w_next_word;

    function automatic logic is_halt(input logic [INST_WIDTH-1:0] word);
        return word[INST_WIDTH-1 -: 2] == HALT_OPCODE;
    endfunction

    assign w_running   = (state_q == S_RUN);
    assign w_wr_ok     = bus_s.wr_en && !w_running;
    assign w_handshake = valid_q && bus_s.inst_ready;
    assign w_pc_d      = pc_q + 1'b1;   // AW bits: wraps at INST_COUNT
    assign w_next_word = mem_q[w_pc_d];

    // A same-cycle write to the start address is forwarded so the first word
    // reflects the value being committed.
    assign w_start_word = (w_wr_ok && (bus_s.wr_addr == bus_s.start_addr))
                        ? bus_s.wr_data : mem_q[bus_s.start_addr];

    // Program storage: cleared to halt words on reset, writable when not running.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < INST_COUNT; i++) begin
                mem_q[i] <= c_HALT_WORD;
            end
        end else if (w_wr_ok) begin
            mem_q[bus_s.wr_addr] <= bus_s.wr_data;
        end
    end

    // Sequencer FSM with registered stream outputs and status pulses.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            inst_q   <= c_HALT_WORD;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: begin
                    // stop beats start; stop alone is a no-op here
                    if (bus_s.start && !bus_s.stop) begin
                        pc_q   <= bus_s.start_addr;
                        inst_q <= w_start_word;
                        if (is_halt(w_start_word)) begin
                            state_q <= S_HALT;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    wr_err_q <= bus_s.wr_en;
                    if (bus_s.stop) begin
                        // any concurrent handshake consumes the current word;
                        // nothing further is fetched
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end else if (w_handshake) begin
                        pc_q   <= w_pc_d;
                        inst_q <= w_next_word;
                        if (is_halt(w_next_word)) begin
                            state_q <= S_HALT;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_s.inst_out   = inst_q;
    assign bus_s.inst_pc    = pc_q;
    assign bus_s.inst_valid = valid_q;
    assign bus_s.busy       = w_running;
    assign bus_s.done       = done_q;
    assign bus_s.wr_err     = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_seq_buff.sv
// ============================================================================
// Module      : tb_inst_seq_buff
// Description : Directed self-checking bench for inst_seq_buff.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_seq_buff;

    localparam int          c_W    = 25;
    localparam int          c_AW   = 6;
    localparam logic [24:0] c_HALT = 25'h1800000;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    inst_seq_buff_if #(.INST_WIDTH(c_W), .AW(c_AW)) bus ();

    inst_seq_buff #(.INST_WIDTH(c_W), .INST_COUNT(64), .HALT_OPCODE(2'b11)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus_s    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [24:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.wr_err !== 1'b0 || bus.inst_out !== c_HALT || bus.inst_pc !== 6'd0) begin
            n_err++;
            $display("FAIL reset_state: v=%b b=%b d=%b e=%b out=%h pc=%0d, want 0 0 0 0 %h 0",
                     bus.inst_valid, bus.busy, bus.done, bus.wr_err, bus.inst_out, bus.inst_pc, c_HALT);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_empty_start();
        bus.start = 1'b1; bus.start_addr = 6'd0;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.inst_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL empty_start: done=%b valid=%b busy=%b, want 1 0 0",
                     bus.done, bus.inst_valid, bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.inst_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL empty_after: done=%b valid=%b busy=%b, want 0 0 0",
                     bus.done, bus.inst_valid, bus.busy);
        end
    endtask

    task automatic test_stream_basic();
        for (int i = 0; i < 4; i++) wr(6'(i), 25'(i + 1));
        wr(6'd4, c_HALT);
        bus.inst_ready = 1'b1;
        bus.start = 1'b1; bus.start_addr = 6'd0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'(i) ||
                bus.inst_out !== 25'(i + 1) || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL basic_word%0d: v=%b pc=%0d out=%h busy=%b, want 1 %0d %h 1",
                         i, bus.inst_valid, bus.inst_pc, bus.inst_out, bus.busy, i, i + 1);
            end
            tick();
        end
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_halt: v=%b done=%b busy=%b, want 0 1 0",
                     bus.inst_valid, bus.done, bus.busy);
        end
        bus.inst_ready = 1'b0;
        tick();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_pulse: done=%b, want 0", bus.done);
        end
    endtask

    task automatic test_backpressure();
        int          got;
        int          dones;
        logic        hold;
        logic [5:0]  h_pc;
        logic [24:0] h_out;
        got = 0; dones = 0; hold = 1'b0; h_pc = '0; h_out = '0;
        bus.inst_ready = 1'b0;
        bus.start = 1'b1; bus.start_addr = 6'd0;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus.done === 1'b1) dones++;
            if (hold) begin
                n_cmp++;
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== h_pc || bus.inst_out !== h_out) begin
                    n_err++;
                    $display("FAIL bp_hold: v=%b pc=%0d out=%h, want 1 %0d %h",
                             bus.inst_valid, bus.inst_pc, bus.inst_out, h_pc, h_out);
                end
            end
            bus.inst_ready = ((cyc % 2) == 1);
            if (bus.inst_valid === 1'b1 && bus.inst_ready) begin
                n_cmp++;
                if (bus.inst_pc !== 6'(got) || bus.inst_out !== 25'(got + 1)) begin
                    n_err++;
                    $display("FAIL bp_word%0d: pc=%0d out=%h, want %0d %h",
                             got, bus.inst_pc, bus.inst_out, got, got + 1);
                end
                got++;
            end
            hold  = (bus.inst_valid === 1'b1) && !bus.inst_ready;
            h_pc  = bus.inst_pc;
            h_out = bus.inst_out;
            tick();
        end
        bus.inst_ready = 1'b0;
        n_cmp++;
        if (got != 4 || dones != 1) begin
            n_err++;
            $display("FAIL bp_count: words=%0d dones=%0d, want 4 1", got, dones);
        end
    endtask

    task automatic test_wrap();
        logic [5:0]  ep [3];
        logic [24:0] ed [3];
        ep = '{6'd62, 6'd63, 6'd0};
        ed = '{25'hA, 25'hB, 25'hC};
        wr(6'd62, 25'hA); wr(6'd63, 25'hB); wr(6'd0, 25'hC); wr(6'd1, c_HALT);
        bus.inst_ready = 1'b1;
        bus.start = 1'b1; bus.start_addr = 6'd62;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== ep[i] || bus.inst_out !== ed[i]) begin
                n_err++;
                $display("FAIL wrap_word%0d: v=%b pc=%0d out=%h, want 1 %0d %h",
                         i, bus.inst_valid, bus.inst_pc, bus.inst_out, ep[i], ed[i]);
            end
            tick();
        end
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_halt: v=%b done=%b, want 0 1", bus.inst_valid, bus.done);
        end
        bus.inst_ready = 1'b0;
        tick();
    endtask

    task automatic test_write_err_stop();
        // program 0..3 = 1..4, 4 = halt, 5 = 0x55 (5 is beyond the halt)
        wr(6'd0, 25'h1); wr(6'd1, 25'h2); wr(6'd5, 25'h55);
        bus.inst_ready = 1'b0;
        bus.start = 1'b1; bus.start_addr = 6'd0;
        tick();
        bus.start = 1'b0;
        wr(6'd5, 25'h99);
        n_cmp++;
        if (bus.wr_err !== 1'b1 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'd0) begin
            n_err++;
            $display("FAIL run_wr_err: err=%b v=%b pc=%0d, want 1 1 0",
                     bus.wr_err, bus.inst_valid, bus.inst_pc);
        end
        tick();
        n_cmp++;
        if (bus.wr_err !== 1'b0) begin
            n_err++;
            $display("FAIL run_wr_err_pulse: err=%b, want 0", bus.wr_err);
        end
        bus.inst_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'd2 || bus.inst_out !== 25'h3) begin
            n_err++;
            $display("FAIL stop_pre: v=%b pc=%0d out=%h, want 1 2 3",
                     bus.inst_valid, bus.inst_pc, bus.inst_out);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.inst_ready = 1'b0;
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL stop_state: v=%b busy=%b done=%b, want 0 0 0",
                     bus.inst_valid, bus.busy, bus.done);
        end
        tick();
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL stop_after: v=%b done=%b, want 0 0", bus.inst_valid, bus.done);
        end
        // mem[5] must still hold the value loaded before the run
        bus.inst_ready = 1'b1;
        bus.start = 1'b1; bus.start_addr = 6'd5;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'd5 || bus.inst_out !== 25'h55) begin
            n_err++;
            $display("FAIL mem5_kept: v=%b pc=%0d out=%h, want 1 5 55",
                     bus.inst_valid, bus.inst_pc, bus.inst_out);
        end
        tick();
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL mem5_halt: v=%b done=%b, want 0 1", bus.inst_valid, bus.done);
        end
        bus.inst_ready = 1'b0;
        tick();
    endtask

    task automatic test_forward_and_reset();
        // stop together with start: nothing starts
        bus.start = 1'b1; bus.start_addr = 6'd0; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL stop_start: v=%b busy=%b done=%b, want 0 0 0",
                     bus.inst_valid, bus.busy, bus.done);
        end
        // write + start to the same address forwards the new data
        bus.wr_en = 1'b1; bus.wr_addr = 6'd7; bus.wr_data = 25'h15;
        bus.start = 1'b1; bus.start_addr = 6'd7;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        n_cmp++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'd7 || bus.inst_out !== 25'h15 ||
            bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL forward: v=%b pc=%0d out=%h busy=%b, want 1 7 15 1",
                     bus.inst_valid, bus.inst_pc, bus.inst_out, bus.busy);
        end
        tick();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.wr_err !== 1'b0 || bus.inst_out !== c_HALT || bus.inst_pc !== 6'd0) begin
            n_err++;
            $display("FAIL async_reset: v=%b b=%b d=%b e=%b out=%h pc=%0d, want 0 0 0 0 %h 0",
                     bus.inst_valid, bus.busy, bus.done, bus.wr_err, bus.inst_out, bus.inst_pc, c_HALT);
        end
        tick();
        reset_n = 1'b1;
        tick();
        // contents lost: the forwarded word at 7 is a halt word again
        bus.start = 1'b1; bus.start_addr = 6'd7;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mem_cleared: done=%b v=%b, want 1 0", bus.done, bus.inst_valid);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n        = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.stop       = 1'b0;
        bus.inst_ready = 1'b0;
        test_reset();
        test_empty_start();
        test_stream_basic();
        test_backpressure();
        test_wrap();
        test_write_err_stop();
        test_forward_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
